// File: rtl/rps_match_controller.sv
// Best-of-N rock-paper-scissors match controller: captures a player press, draws a
// computer choice from an LFSR, scores the round, holds the result, declares the match.
module rps_match_controller #(
  parameter int          ROUNDS_TO_WIN = 2,
  parameter int          SCORE_W       = 4,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  parameter int          RESULT_HOLD   = 50_000_000,
  parameter int          HOLD_W        = 26
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               rock_button,
  input  logic               paper_button,
  input  logic               scissors_button,
  input  logic               new_match,
  input  logic               cpu_force_en,
  input  logic [1:0]         cpu_force_choice,
  output logic [1:0]         player_choice,
  output logic [1:0]         computer_choice,
  output logic               win_led,
  output logic               lose_led,
  output logic               tie_led,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] computer_score,
  output logic [SCORE_W-1:0] round_count,
  output logic               match_over
);

  localparam logic [7:0]         SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [SCORE_W-1:0] WIN_CNT  = SCORE_W'(ROUNDS_TO_WIN);
  localparam logic [HOLD_W-1:0]  HOLD_LD  = HOLD_W'(RESULT_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_SCORE,
    S_SHOW,
    S_MATCH_END
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         lfsr_q;
  logic [2:0]         prev_q;
  logic [1:0]         player_q, player_d;
  logic [1:0]         comp_q, comp_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               tie_q, tie_d;
  logic [SCORE_W-1:0] pscore_q, pscore_d;
  logic [SCORE_W-1:0] cscore_q, cscore_d;
  logic [SCORE_W-1:0] rcount_q, rcount_d;
  logic               match_q, match_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [2:0]         btn;
  logic [2:0]         edges;
  logic               press_valid;
  logic [1:0]         press_code;

  // Encoding: 01 rock, 10 paper, 11 scissors.
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == 2'b01) && (b == 2'b11)) ||
           ((a == 2'b10) && (b == 2'b01)) ||
           ((a == 2'b11) && (b == 2'b10));
  endfunction

  assign btn   = {scissors_button, paper_button, rock_button};
  assign edges = btn & ~prev_q;

  always_comb begin
    press_valid = 1'b1;
    press_code  = 2'b00;
    case (edges)
      3'b001:  press_code = 2'b01;
      3'b010:  press_code = 2'b10;
      3'b100:  press_code = 2'b11;
      default: press_valid = 1'b0;
    endcase
  end

  // The LFSR free-runs in every state so the draw depends on press timing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED_EFF;
      prev_q <= 3'b111;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      prev_q <= btn;
    end
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    comp_d   = comp_q;
    win_d    = win_q;
    lose_d   = lose_q;
    tie_d    = tie_q;
    pscore_d = pscore_q;
    cscore_d = cscore_q;
    rcount_d = rcount_q;
    match_d  = match_q;
    hold_d   = hold_q;

    if (new_match) begin
      state_d  = S_IDLE;
      player_d = 2'b00;
      comp_d   = 2'b00;
      win_d    = 1'b0;
      lose_d   = 1'b0;
      tie_d    = 1'b0;
      pscore_d = '0;
      cscore_d = '0;
      rcount_d = '0;
      match_d  = 1'b0;
      hold_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press_valid) begin
            player_d = press_code;
            state_d  = S_DRAW;
          end
        end
        S_DRAW: begin
          if (cpu_force_en && (cpu_force_choice != 2'b00)) begin
            comp_d  = cpu_force_choice;
            state_d = S_SCORE;
          end else if (lfsr_q[1:0] != 2'b00) begin
            comp_d  = lfsr_q[1:0];
            state_d = S_SCORE;
          end
        end
        S_SCORE: begin
          if (rcount_q != '1) rcount_d = rcount_q + SCORE_W'(1);
          if (player_q == comp_q) begin
            tie_d = 1'b1;
          end else if (beats(player_q, comp_q)) begin
            win_d    = 1'b1;
            pscore_d = pscore_q + SCORE_W'(1);
          end else begin
            lose_d   = 1'b1;
            cscore_d = cscore_q + SCORE_W'(1);
          end
          hold_d  = HOLD_LD;
          state_d = S_SHOW;
        end
        S_SHOW: begin
          if (hold_q == '0) begin
            if ((pscore_q == WIN_CNT) || (cscore_q == WIN_CNT)) begin
              state_d = S_MATCH_END;
              match_d = 1'b1;
              tie_d   = 1'b0;
              win_d   = (pscore_q == WIN_CNT);
              lose_d  = (pscore_q != WIN_CNT);
            end else begin
              state_d = S_IDLE;
              win_d   = 1'b0;
              lose_d  = 1'b0;
              tie_d   = 1'b0;
            end
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        S_MATCH_END: state_d = S_MATCH_END;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      player_q <= 2'b00;
      comp_q   <= 2'b00;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      tie_q    <= 1'b0;
      pscore_q <= '0;
      cscore_q <= '0;
      rcount_q <= '0;
      match_q  <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      comp_q   <= comp_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      tie_q    <= tie_d;
      pscore_q <= pscore_d;
      cscore_q <= cscore_d;
      rcount_q <= rcount_d;
      match_q  <= match_d;
      hold_q   <= hold_d;
    end
  end

  assign player_choice   = player_q;
  assign computer_choice = comp_q;
  assign win_led         = win_q;
  assign lose_led        = lose_q;
  assign tie_led         = tie_q;
  assign player_score    = pscore_q;
  assign computer_score  = cscore_q;
  assign round_count     = rcount_q;
  assign match_over      = match_q;

endmodule

// File: doc/rps_match_controller.md
Name: rps_match_controller

Overview:
- Best-of-N Rock-Paper-Scissors match controller and the next generation of the single-round game controller.
- Captures the player's choice on a button edge and draws a computer choice from an internal LFSR.
- Scores each round, holds the round result on LEDs for a programmable time, and declares the match winner once either side reaches ROUNDS_TO_WIN.
- Sits between the debounced button synchronisers and the board LEDs/7-seg score display.

Parameters:
- ROUNDS_TO_WIN, 2, wins needed to take the match (2 = best-of-3); range 1..2^SCORE_W-1.
- SCORE_W, 4, width of the score and round counters.
- LFSR_SEED, 8'hA5, LFSR reset value; 0 is replaced by 8'h01.
- RESULT_HOLD, 50_000_000, cycles the round result is held in SHOW; must be at least 1.
- HOLD_W, 26, width of the hold counter; must satisfy 2^HOLD_W > RESULT_HOLD.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- rock_button  in  1  synchronised, debounced level
- paper_button  in  1  synchronised, debounced level
- scissors_button  in  1  synchronised, debounced level
- new_match  in  1  synchronous pulse; clears scores and returns to IDLE
- cpu_force_en  in  1  test hook: use cpu_force_choice instead of the LFSR
- cpu_force_choice  in  2  forced computer choice (01/10/11)
- player_choice  out  2  latched player choice (00 none, 01 rock, 10 paper, 11 scissors)
- computer_choice  out  2  latched computer choice, same encoding
- win_led  out  1  round or match won
- lose_led  out  1  round or match lost
- tie_led  out  1  round tied
- player_score  out  SCORE_W  rounds won by the player
- computer_score  out  SCORE_W  rounds won by the computer
- round_count  out  SCORE_W  rounds played including ties; saturates at all-ones
- match_over  out  1  high in MATCH_END

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; every output goes to 0.
  - LFSR loads LFSR_SEED, or 8'h01 if the seed is 0.
  - Button edge-detect history registers load 1, so buttons already held at reset release produce no edge.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. fb = q[7]^q[5]^q[4]^q[3]; q <= {q[6:0],fb}. It advances every cycle in every state and is never cleared by new_match.
- Edge detect: edge_x = button_x & ~prev_x, with prev registered every cycle.
  - A valid press is exactly one rising edge in a cycle.
  - Two or three simultaneous edges are ignored; no state change.
- IDLE:
  - On a valid press at cycle t: player_choice takes the new code at t+1 and the state goes to DRAW.
  - LEDs are 0 in IDLE. The previous round's choices stay visible until overwritten.
- DRAW (computer choice selection):
  - If cpu_force_en=1 and cpu_force_choice!=00: computer_choice <= cpu_force_choice.
  - Otherwise, if q[1:0]!=00: computer_choice <= q[1:0].
  - Otherwise stay in DRAW and resample the next cycle.
  - On capture, the state goes to SCORE. DRAW latency is at least 1 cycle.
- SCORE (exactly 1 cycle):
  - Win rules: rock beats scissors, paper beats rock, scissors beats paper. Equal choices are a tie.
  - On a player win, player_score increments; on a loss, computer_score increments. Ties leave both scores unchanged.
  - round_count increments, saturating at all-ones.
  - The matching LED (exactly one of win/lose/tie) is registered high and the hold counter is loaded.
  - Next state is SHOW.
- SHOW:
  - The LED is held for exactly RESULT_HOLD cycles; button edges are ignored.
  - At expiry, if either score equals ROUNDS_TO_WIN, go to MATCH_END. Otherwise clear the LEDs and go to IDLE.
- MATCH_END:
  - match_over=1; tie_led=0.
  - win_led=1 if player_score==ROUNDS_TO_WIN, else lose_led=1.
  - Stays here until new_match; buttons are ignored.
- new_match, in any state:
  - Next cycle: IDLE, with both scores, round_count, both choices, LEDs, match_over and the hold counter all cleared.
  - It takes priority over any button edge in the same cycle.
- Reset mid-round abandons the round; scores are lost.
- Invariants:
  - At most one of win/lose/tie is high.
  - Scores never exceed ROUNDS_TO_WIN.
  - Player choice latency from edge to register is 1 cycle.

Test Plan:
1. Reset with rock_button held high, then release reset -> no round starts. All outputs stay 0 and the state stays IDLE until rock is released and pressed again.
2. cpu_force_en=1, force=11, RESULT_HOLD=4; pulse rock -> player_choice=01 one cycle after the edge. computer_choice=11, win_led=1 for exactly 4 cycles, player_score=1, round_count=1.
3. Force 01; press rock (tie), then force 10 and press rock (loss) -> the tie gives tie_led with scores 0/0. The loss gives lose_led with computer_score=1 and round_count=2.
4. ROUNDS_TO_WIN=2, force 11; press rock twice -> after the second SHOW, match_over=1, win_led=1, player_score=2. A further paper press is ignored; new_match clears all outputs to 0 next cycle.
5. Edges on rock and paper in the same cycle in IDLE -> no change. Rock pressed during SHOW -> ignored, scores unchanged.
6. cpu_force_en=0, LFSR_SEED=8'h00 -> LFSR starts at 01, computer_choice is never 00, and DRAW loops while q[1:0]=00. A reference-model LFSR matches the captured choices over 100 rounds.
